// File: rtl/root_pkg.sv
// Shared types and widths for the Root engine arbiter: FSM encoding and
// Q10.10 operand/result widths.
package root_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int FRAC_W = 10;
  localparam int RES_W  = 20;
  localparam int BASE_W = 10;
  localparam int EXP_W  = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set request at or after rr_ptr,
// wrapping at NUM_REQ. Zero latency, no state.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               found
);

  logic [ID_W:0] idx;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      if (idx >= (ID_W + 1)'(NUM_REQ)) idx = idx - (ID_W + 1)'(NUM_REQ);
      if (req[idx[ID_W-1:0]]) winner = idx[ID_W-1:0];
    end
    found = |req;
  end

endmodule

// File: rtl/root_req_arbiter.sv
// Round-robin share of one Root engine among NUM_REQ requesters; result held until the owner
// accepts it. Optional WAIT watchdog enabled by defining ROOT_ARB_TIMEOUT_EN.
module root_req_arbiter
  import root_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*BASE_W-1:0] req_base,
  input  logic [NUM_REQ*EXP_W-1:0]  req_exp,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [RES_W-1:0]          resp_data,
  output logic                      resp_err,
  output logic                      eng_in_valid,
  output logic [BASE_W-1:0]         eng_in_data_1,
  output logic [EXP_W-1:0]          eng_in_data_2,
  input  logic                      eng_out_valid,
  input  logic [RES_W-1:0]          eng_out_data,
  output logic                      eng_rst_n,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            tmo_hit;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_picker (
    .req   (req_valid),
    .rr_ptr(rr_ptr),
    .winner(winner),
    .found (found)
  );

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (state == IDLE && found) req_ready[winner] = 1'b1;
    if (state == RESP) resp_valid[grant_id] = 1'b1;
  end

  assign eng_in_valid = (state == LAUNCH);
  assign busy         = (state != IDLE);

`ifdef ROOT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;

  // A result arriving on the expiry cycle wins over the watchdog.
  assign tmo_hit   = (state == WAIT) && !eng_out_valid && (wait_cnt == CNT_W'(TIMEOUT_CYC));
  assign eng_rst_n = ~tmo_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      resp_err <= 1'b0;
    end else begin
      if (state == LAUNCH) wait_cnt <= '0;
      else if (state == WAIT && !tmo_hit) wait_cnt <= wait_cnt + 1'b1;

      if (state == WAIT) begin
        if (eng_out_valid) resp_err <= 1'b0;
        else if (tmo_hit)  resp_err <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign eng_rst_n = 1'b1;
  assign resp_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      eng_in_data_1 <= '0;
      eng_in_data_2 <= '0;
      resp_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            eng_in_data_1 <= req_base[winner*BASE_W +: BASE_W];
            eng_in_data_2 <= req_exp[winner*EXP_W +: EXP_W];
            grant_id      <= winner;
            rr_ptr        <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          if (eng_out_valid) begin
            resp_data <= eng_out_data;
            state     <= RESP;
          end else if (tmo_hit) begin
            resp_data <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (resp_ready[grant_id]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_root_req_arbiter.sv
// Directed bench for root_req_arbiter with a fixed-latency engine model answering from a
// small table of hand-computed roots.
module tb_root_req_arbiter;

  localparam int N       = 4;
  localparam int ENG_LAT = 3;
  localparam int TMO     = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*10-1:0] req_base;
  logic [N*3-1:0]  req_exp;
  logic [N-1:0]  resp_valid;
  logic [N-1:0]  resp_ready;
  logic [19:0]   resp_data;
  logic          resp_err;
  logic          eng_in_valid;
  logic [9:0]    eng_in_data_1;
  logic [2:0]    eng_in_data_2;
  logic          eng_out_valid = 1'b0;
  logic [19:0]   eng_out_data  = '0;
  logic          eng_rst_n;
  logic          busy;
  logic [1:0]    grant_id;

  int checks   = 0;
  int fails    = 0;
  int launches = 0;
  int eng_cnt  = 0;
  bit eng_mute = 1'b0;

  always #5 clk = ~clk;

  root_req_arbiter #(
    .NUM_REQ    (N),
    .ID_W       (2),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_base     (req_base),
    .req_exp      (req_exp),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .eng_in_valid (eng_in_valid),
    .eng_in_data_1(eng_in_data_1),
    .eng_in_data_2(eng_in_data_2),
    .eng_out_valid(eng_out_valid),
    .eng_out_data (eng_out_data),
    .eng_rst_n    (eng_rst_n),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  function automatic logic [19:0] eng_fn(input logic [9:0] b, input logic [2:0] e);
    if (e == 3'd1) return {b, 10'd0};
    if (b == 10'd4 && e == 3'd2) return 20'h00800;
    if (b == 10'd27 && e == 3'd3) return 20'h00C00;
    return 20'hFFFFF;
  endfunction

  // Engine model reads operands when it answers, so unstable operands show up in the result.
  always @(negedge clk) begin
    eng_out_valid = 1'b0;
    if (!rst_n || !eng_rst_n) begin
      eng_cnt = 0;
    end else if (eng_in_valid) begin
      eng_cnt = ENG_LAT;
      launches++;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0 && !eng_mute) begin
        eng_out_valid = 1'b1;
        eng_out_data  = eng_fn(eng_in_data_1, eng_in_data_2);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int idx, input logic [9:0] b, input logic [2:0] e, output bit ok);
    req_base[idx*10 +: 10] = b;
    req_exp[idx*3 +: 3]    = e;
    req_valid[idx]         = 1'b1;
    #1;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_resp(input int idx, output bit ok, output bit stable);
    logic [9:0] d1;
    logic [2:0] d2;
    d1     = eng_in_data_1;
    d2     = eng_in_data_2;
    ok     = 1'b0;
    stable = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (resp_valid[idx]) begin
        ok = 1'b1;
        break;
      end
      if (eng_in_data_1 !== d1 || eng_in_data_2 !== d2) stable = 1'b0;
      tick();
    end
  endtask

  task automatic release_resp(input int idx);
    resp_ready[idx] = 1'b1;
    tick();
    resp_ready[idx] = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0 || resp_valid !== 4'b0 || eng_in_valid !== 1'b0 || resp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_valids: req_ready=%b resp_valid=%b eng_in_valid=%b resp_err=%b, want all 0",
               req_ready, resp_valid, eng_in_valid, resp_err);
    end
    checks++;
    if (eng_in_data_1 !== 10'd0 || eng_in_data_2 !== 3'd0 || resp_data !== 20'd0 || grant_id !== 2'd0) begin
      fails++;
      $display("FAIL reset_data: d1=%h d2=%h resp_data=%h grant_id=%0d, want 0", eng_in_data_1,
               eng_in_data_2, resp_data, grant_id);
    end
    checks++;
    if (eng_rst_n !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: eng_rst_n=%b busy=%b, want 1/0", eng_rst_n, busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    bit ok, stable;
    int l0;
    l0 = launches;
    issue(0, 10'd4, 3'd2, ok);
    checks++;
    if (!ok || grant_id !== 2'd0 || eng_in_data_1 !== 10'd4 || eng_in_data_2 !== 3'd2) begin
      fails++;
      $display("FAIL single_grant: ok=%b grant_id=%0d d1=%0d d2=%0d, want 1/0/4/2", ok, grant_id,
               eng_in_data_1, eng_in_data_2);
    end
    wait_resp(0, ok, stable);
    checks++;
    if (!ok || resp_valid !== 4'b0001 || resp_data !== 20'h00800 || resp_err !== 1'b0) begin
      fails++;
      $display("FAIL single_resp: ok=%b resp_valid=%b data=%h err=%b, want 1/0001/00800/0", ok,
               resp_valid, resp_data, resp_err);
    end
    checks++;
    if (launches - l0 !== 1) begin
      fails++;
      $display("FAIL single_launch: %0d start pulses, want 1", launches - l0);
    end
    tick();
    tick();
    checks++;
    if (resp_valid !== 4'b0001 || resp_data !== 20'h00800) begin
      fails++;
      $display("FAIL single_hold: resp_valid=%b data=%h, want 0001/00800", resp_valid, resp_data);
    end
    release_resp(0);
    checks++;
    if (resp_valid !== 4'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_release: resp_valid=%b busy=%b, want 0/0", resp_valid, busy);
    end
  endtask

  task automatic test_sequence;
    bit ok, stable;
    issue(1, 10'd27, 3'd3, ok);
    wait_resp(1, ok, stable);
    checks++;
    if (!ok || !stable || resp_data !== 20'h00C00 || resp_valid !== 4'b0010) begin
      fails++;
      $display("FAIL seq_cuberoot: ok=%b stable=%b data=%h resp_valid=%b, want 1/1/00C00/0010", ok,
               stable, resp_data, resp_valid);
    end
    release_resp(1);
    issue(2, 10'd9, 3'd1, ok);
    wait_resp(2, ok, stable);
    checks++;
    if (!ok || !stable || resp_data !== 20'h02400 || resp_valid !== 4'b0100) begin
      fails++;
      $display("FAIL seq_exp1: ok=%b stable=%b data=%h resp_valid=%b, want 1/1/02400/0100", ok,
               stable, resp_data, resp_valid);
    end
    release_resp(2);
  endtask

  task automatic test_round_robin;
    int order[5];
    logic [19:0] exp_data[5];
    bit ok, stable;
    int w;
    order    = '{0, 1, 2, 3, 0};
    exp_data = '{20'h02800, 20'h02C00, 20'h03000, 20'h03400, 20'h02800};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_base[i*10 +: 10] = 10'(10 + i);
      req_exp[i*3 +: 3]    = 3'd1;
    end
    req_valid = 4'hF;
    #1;
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 20; c++) begin
        if (req_ready != 4'b0) break;
        tick();
      end
      w = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) w = i;
      checks++;
      if (w !== order[n]) begin
        fails++;
        $display("FAIL rr_order[%0d]: granted %0d, want %0d", n, w, order[n]);
      end
      tick();
      wait_resp(order[n], ok, stable);
      checks++;
      if (!ok || resp_data !== exp_data[n]) begin
        fails++;
        $display("FAIL rr_data[%0d]: ok=%b data=%h, want 1/%h", n, ok, resp_data, exp_data[n]);
      end
      release_resp(order[n]);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_back_pressure;
    bit ok, stable;
    issue(3, 10'd5, 3'd1, ok);
    req_base[9:0]  = 10'd6;
    req_exp[2:0]   = 3'd1;
    req_valid[0]   = 1'b1;
    resp_ready[0]  = 1'b1;
    wait_resp(3, ok, stable);
    checks++;
    if (!ok || resp_data !== 20'h01400) begin
      fails++;
      $display("FAIL bp_first: ok=%b data=%h, want 1/01400", ok, resp_data);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (resp_valid !== 4'b1000 || resp_data !== 20'h01400 || eng_in_valid !== 1'b0 || req_ready !== 4'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: resp_valid=%b data=%h eng_in_valid=%b req_ready=%b, want 1000/01400/0/0000",
                 c, resp_valid, resp_data, eng_in_valid, req_ready);
      end
    end
    resp_ready = 4'b1000;
    tick();
    resp_ready = '0;
    #1;
    checks++;
    if (resp_valid !== 4'b0 || req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL bp_release: resp_valid=%b req_ready=%b, want 0000/0001", resp_valid, req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    wait_resp(0, ok, stable);
    checks++;
    if (!ok || resp_data !== 20'h01800 || grant_id !== 2'd0) begin
      fails++;
      $display("FAIL bp_next: ok=%b data=%h grant_id=%0d, want 1/01800/0", ok, resp_data, grant_id);
    end
    release_resp(0);
  endtask

  task automatic test_reset_in_wait;
    bit ok, stable;
    issue(1, 10'd8, 3'd1, ok);
    tick();
    checks++;
    if (busy !== 1'b1 || eng_in_valid !== 1'b0 || resp_valid !== 4'b0) begin
      fails++;
      $display("FAIL rw_in_wait: busy=%b eng_in_valid=%b resp_valid=%b, want 1/0/0000", busy,
               eng_in_valid, resp_valid);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || resp_valid !== 4'b0 || req_ready !== 4'b0 || eng_in_valid !== 1'b0 ||
        eng_rst_n !== 1'b1 || resp_err !== 1'b0) begin
      fails++;
      $display("FAIL rw_ctrl: busy=%b resp_valid=%b req_ready=%b eng_in_valid=%b eng_rst_n=%b err=%b",
               busy, resp_valid, req_ready, eng_in_valid, eng_rst_n, resp_err);
    end
    checks++;
    if (eng_in_data_1 !== 10'd0 || eng_in_data_2 !== 3'd0 || resp_data !== 20'd0 || grant_id !== 2'd0) begin
      fails++;
      $display("FAIL rw_data: d1=%h d2=%h data=%h grant_id=%0d, want 0", eng_in_data_1, eng_in_data_2,
               resp_data, grant_id);
    end
    rst_n = 1'b1;
    tick();
    issue(2, 10'd3, 3'd1, ok);
    wait_resp(2, ok, stable);
    checks++;
    if (!ok || !stable || resp_data !== 20'h00C00 || resp_err !== 1'b0) begin
      fails++;
      $display("FAIL rw_after: ok=%b stable=%b data=%h err=%b, want 1/1/00C00/0", ok, stable,
               resp_data, resp_err);
    end
    release_resp(2);
  endtask

`ifdef ROOT_ARB_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    int rst_low;
    eng_mute = 1'b1;
    rst_low  = 0;
    issue(2, 10'd7, 3'd1, ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (resp_valid[2]) begin
        ok = 1'b1;
        break;
      end
      if (eng_rst_n === 1'b0) rst_low++;
      tick();
    end
    checks++;
    if (!ok || rst_low !== 1) begin
      fails++;
      $display("FAIL tmo_eng_rst: ok=%b eng_rst_n low %0d cycles, want 1/1", ok, rst_low);
    end
    checks++;
    if (resp_err !== 1'b1 || resp_data !== 20'd0 || resp_valid !== 4'b0100) begin
      fails++;
      $display("FAIL tmo_resp: err=%b data=%h resp_valid=%b, want 1/00000/0100", resp_err, resp_data,
               resp_valid);
    end
    release_resp(2);
    eng_mute = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_base   = '0;
    req_exp    = '0;
    resp_ready = '0;
    test_reset();
    test_single();
    test_sequence();
    test_round_robin();
    test_back_pressure();
    test_reset_in_wait();
`ifdef ROOT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
